// File: rtl/m65c02_mmu_pkg.sv
// Shared MMU definitions: loader FSM encoding, status codes, MAP geometry.
package m65c02_mmu_pkg;

  localparam int   MAP_DEPTH = 32;
  localparam int   IDX_W     = 5;
  localparam int   CNT_W     = IDX_W + 1;
  localparam int   LAST_W    = IDX_W + 2;

  // Byte lane within a 16-bit MAP entry (drives MMU VA[0])
  localparam logic BYTE_LO   = 1'b0;   // PA/CS byte
  localparam logic BYTE_HI   = 1'b1;   // WS/Rsvd byte

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MRD     = 3'd1,
    ST_MWR_MAP = 3'd2,
    ST_MRD_MAP = 3'd3,
    ST_MWR     = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_e;

  // A run is legal when it is non-empty and stays inside the MAP
  function automatic logic range_ok(input logic [IDX_W-1:0] first,
                                    input logic [CNT_W-1:0] count);
    logic [LAST_W-1:0] last;
    last = {2'b00, first} + {1'b0, count};
    return (count != '0) && (last <= LAST_W'(MAP_DEPTH));
  endfunction

endpackage

// File: rtl/m65c02_map_loader_tmr.sv
// Memory-acknowledge wait counter; expires after pTO request cycles without Mem_Ack.
module m65c02_map_loader_tmr #(
  parameter int pTO = 15
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(pTO - 1);

  logic [7:0] cnt;

  // Count un-acknowledged request cycles; cleared whenever no request is pending
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 8'd1;
  end

  // The pTO-th waiting cycle without an ack ends the request
  assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/m65c02_map_loader.sv
// MAP block-transfer sequencer: loads MMU map entries from memory or saves them back.
module m65c02_map_loader
  import m65c02_mmu_pkg::*;
#(
  parameter int pAW = 20,
  parameter int pTO = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Dir,
  input  logic [pAW-1:0]   Base,
  input  logic [4:0]       First,
  input  logic [5:0]       Count,
  input  logic             Abort,
  output logic             Mem_Req,
  output logic             Mem_WE,
  output logic [pAW-1:0]   Mem_Addr,
  output logic [7:0]       Mem_DO,
  input  logic [7:0]       Mem_DI,
  input  logic             Mem_Ack,
  output logic             Sel_MAP,
  output logic             MAP_WE,
  output logic             MAP_RE,
  output logic [4:0]       Sel,
  output logic             Byte,
  output logic             MAP_Rdy,
  output logic [7:0]       MMU_DI,
  input  logic [7:0]       MMU_DO,
  output logic             Busy,
  output logic             Hold,
  output logic             Done,
  output logic [1:0]       Err
);

  state_e               state, state_nxt;
  logic [pAW-1:0]       addr_q;      // image address of current entry's low byte
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;       // entries remaining, including the current one
  logic                 byte_q;
  logic [7:0]           data_q;
  err_e                 err_q;
  logic                 abort_q;     // abort seen while a memory request was pending

  logic accept, bad_start, req_wait, tmr_expire, abort_any;
  logic byte_done, last_entry, set_timeout, set_abort;

  assign accept     = (state == ST_IDLE) && Start &&  range_ok(First, Count);
  assign bad_start  = (state == ST_IDLE) && Start && !range_ok(First, Count);
  assign req_wait   = (state == ST_MRD) || (state == ST_MWR);
  assign abort_any  = Abort || abort_q;
  assign last_entry = (cnt_q == CNT_W'(1));
  assign byte_done  = (state == ST_MWR_MAP) || ((state == ST_MWR) && Mem_Ack);

  m65c02_map_loader_tmr #(.pTO(pTO)) u_tmr (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr    (!req_wait),
    .en     (req_wait && !Mem_Ack),
    .expire (tmr_expire)
  );

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; timeout outranks a pending abort
  // NOTE: defaults first so every path assigns every signal; no latch is inferred.
  always_comb begin
    state_nxt   = state;
    set_timeout = 1'b0;
    set_abort   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = Dir ? ST_MRD_MAP : ST_MRD;
      end
      ST_MRD: begin
        if (tmr_expire) begin
          state_nxt   = ST_IDLE;
          set_timeout = 1'b1;
        end else if (Mem_Ack) begin
          if (abort_any) begin
            state_nxt = ST_IDLE;
            set_abort = 1'b1;
          end else begin
            state_nxt = ST_MWR_MAP;
          end
        end
      end
      ST_MWR_MAP: begin
        if (abort_any) begin
          state_nxt = ST_IDLE;
          set_abort = 1'b1;
        end else if (byte_q == BYTE_HI && last_entry) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_MRD;
        end
      end
      ST_MRD_MAP: begin
        if (abort_any) begin
          state_nxt = ST_IDLE;
          set_abort = 1'b1;
        end else begin
          state_nxt = ST_MWR;
        end
      end
      ST_MWR: begin
        if (tmr_expire) begin
          state_nxt   = ST_IDLE;
          set_timeout = 1'b1;
        end else if (Mem_Ack) begin
          if (abort_any) begin
            state_nxt = ST_IDLE;
            set_abort = 1'b1;
          end else if (byte_q == BYTE_HI && last_entry) begin
            state_nxt = ST_FIN;
          end else begin
            state_nxt = ST_MRD_MAP;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, byte capture, address/index advance and sticky status
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      byte_q <= BYTE_LO;
      data_q <= '0;
      err_q  <= ERR_NONE;
    end else begin
      if (accept) begin
        addr_q <= Base;
        idx_q  <= First;
        cnt_q  <= Count;
        byte_q <= BYTE_LO;
        err_q  <= ERR_NONE;
      end else if (bad_start) begin
        err_q  <= ERR_RANGE;
      end
      if (set_timeout) err_q <= ERR_TIMEOUT;
      if (set_abort)   err_q <= ERR_ABORT;

      if (state == ST_MRD && Mem_Ack) data_q <= Mem_DI;
      if (state == ST_MRD_MAP)        data_q <= MMU_DO;

      if (byte_done) begin
        if (byte_q == BYTE_LO) begin
          byte_q <= BYTE_HI;
        end else begin
          byte_q <= BYTE_LO;
          idx_q  <= idx_q + IDX_W'(1);
          addr_q <= addr_q + pAW'(2);
          cnt_q  <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // Remember an abort raised mid-request until the transfer unwinds
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                        abort_q <= 1'b0;
    else if (state == ST_IDLE || state == ST_FIN)   abort_q <= 1'b0;
    else if (Abort)                                 abort_q <= 1'b1;
  end

  // Moore outputs decoded from the current state
  always_comb begin
    Mem_Req  = 1'b0;
    Mem_WE   = 1'b0;
    Mem_DO   = '0;
    Sel_MAP  = 1'b0;
    MAP_WE   = 1'b0;
    MAP_RE   = 1'b0;
    MAP_Rdy  = 1'b0;
    MMU_DI   = '0;
    Mem_Addr = addr_q + {{(pAW-1){1'b0}}, byte_q};
    Sel      = idx_q;
    Byte     = byte_q;
    Err      = err_q;
    Busy     = (state != ST_IDLE) && (state != ST_FIN);
    Hold     = Busy;
    Done     = (state == ST_FIN);
    unique case (state)
      ST_MRD:     Mem_Req = 1'b1;
      ST_MWR_MAP: begin
        Sel_MAP = 1'b1;
        MAP_WE  = 1'b1;
        MAP_Rdy = 1'b1;
        MMU_DI  = data_q;
      end
      ST_MRD_MAP: begin
        Sel_MAP = 1'b1;
        MAP_RE  = 1'b1;
      end
      ST_MWR: begin
        Mem_Req = 1'b1;
        Mem_WE  = 1'b1;
        Mem_DO  = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m65c02_map_loader.sv
// Randomised scoreboard bench for the MAP loader: memory and MMU are bench models.
module tb_m65c02_map_loader;

  localparam int AW = 20;
  localparam int TO = 15;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0, Dir = 1'b0, Abort = 1'b0;
  logic [AW-1:0] Base = '0;
  logic [4:0]    First = '0;
  logic [5:0]    Count = '0;
  logic          Mem_Req, Mem_WE, Mem_Ack;
  logic [AW-1:0] Mem_Addr;
  logic [7:0]    Mem_DO, Mem_DI, MMU_DI, MMU_DO;
  logic          Sel_MAP, MAP_WE, MAP_RE, Byte, MAP_Rdy, Busy, Hold, Done;
  logic [4:0]    Sel;
  logic [1:0]    Err;

  m65c02_map_loader #(.pAW(AW), .pTO(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Dir(Dir), .Base(Base), .First(First),
    .Count(Count), .Abort(Abort), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
    .Mem_Addr(Mem_Addr), .Mem_DO(Mem_DO), .Mem_DI(Mem_DI), .Mem_Ack(Mem_Ack),
    .Sel_MAP(Sel_MAP), .MAP_WE(MAP_WE), .MAP_RE(MAP_RE), .Sel(Sel), .Byte(Byte),
    .MAP_Rdy(MAP_Rdy), .MMU_DI(MMU_DI), .MMU_DO(MMU_DO), .Busy(Busy), .Hold(Hold),
    .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model: read image + programmable ack delay
  bit [7:0] rd_mem [0:(1<<AW)-1];
  int wait_cnt = 0, req_num = 0, req_base = 0;
  int ack_d = 0, stall_byte = -1, stall_d = 0;

  always @(posedge Clk) begin
    if (!Mem_Req || Mem_Ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (Mem_Req && Mem_Ack)  req_num <= req_num + 1;
  end

  assign Mem_DI  = rd_mem[Mem_Addr];
  assign Mem_Ack = Mem_Req &&
                   (wait_cnt >= (((req_num - req_base) == stall_byte) ? stall_d : ack_d));

  // ---------------- MMU mapping RAM model
  bit [15:0] map_mem [32];
  assign MMU_DO = Byte ? map_mem[Sel][15:8] : map_mem[Sel][7:0];
  always @(posedge Clk) begin
    if (MAP_WE) begin
      if (Byte) map_mem[Sel][15:8] <= MMU_DI;
      else      map_mem[Sel][7:0]  <= MMU_DI;
    end
  end

  // ---------------- reference model and scoreboard
  bit [15:0] ref_map [32];

  typedef struct { bit we; logic [AW-1:0] addr; logic [7:0] data; } mem_t;
  typedef struct { logic [4:0] sel; bit hi; logic [7:0] data; } map_t;
  mem_t mem_q[$];
  map_t map_q[$];

  // Transfer byte j lives at Base+j and belongs to entry First+j/2, lane j%2
  task automatic push_expect(input bit dir, input logic [AW-1:0] base, input int first,
                             input int count, input int n_mem, input int n_map, input int n_commit);
    for (int j = 0; j < 2*count; j++) begin
      logic [AW-1:0] a;
      int  e;
      bit  hi;
      logic [7:0] v;
      a  = base + AW'(j);
      e  = first + j/2;
      hi = (j % 2) == 1;
      if (!dir) begin
        v = rd_mem[a];
        if (j < n_mem) mem_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
        if (j < n_map) map_q.push_back('{sel: 5'(e), hi: hi, data: v});
        if (j < n_commit) begin
          if (hi) ref_map[e][15:8] = v;
          else    ref_map[e][7:0]  = v;
        end
      end else begin
        v = hi ? ref_map[e][15:8] : ref_map[e][7:0];
        if (j < n_mem) mem_q.push_back('{we: 1'b1, addr: a, data: v});
      end
    end
  endtask

  // Monitor: compare every completed memory cycle and MAP write against the queues
  always @(negedge Clk) begin
    mem_t me;
    map_t mp;
    if (!Rst && Mem_Req && Mem_Ack) begin
      check("mem_cycle_expected", 32'(mem_q.size() != 0), 32'd1);
      if (mem_q.size() != 0) begin
        me = mem_q.pop_front();
        check("mem_we",   32'(Mem_WE),   32'(me.we));
        check("mem_addr", 32'(Mem_Addr), 32'(me.addr));
        if (me.we) check("mem_do", 32'(Mem_DO), 32'(me.data));
      end
    end
    if (!Rst && MAP_WE) begin
      check("map_wr_expected", 32'(map_q.size() != 0), 32'd1);
      check("map_rdy", 32'(MAP_Rdy), 32'd1);
      if (map_q.size() != 0) begin
        mp = map_q.pop_front();
        check("map_sel",  32'(Sel),    32'(mp.sel));
        check("map_byte", 32'(Byte),   32'(mp.hi));
        check("map_di",   32'(MMU_DI), 32'(mp.data));
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({Mem_Req, Mem_WE, Sel_MAP, MAP_WE, MAP_RE, Byte, MAP_Rdy,
                              Busy, Hold, Done, Err}), 32'd0);
    check({tag, "_addr"}, 32'(Mem_Addr), 32'd0);
    check({tag, "_data"}, 32'({Sel, MMU_DI, Mem_DO}), 32'd0);
  endtask

  task automatic check_map(input int first, input int count);
    for (int e = first; e < first + count; e++)
      check($sformatf("map_entry_%0d", e), 32'(map_mem[e]), 32'(ref_map[e]));
  endtask

  task automatic fill_image(input logic [AW-1:0] base, input int count);
    for (int j = 0; j < 2*count; j++) rd_mem[base + AW'(j)] = 8'($urandom);
  endtask

  // One transfer: derive expected outcome, issue Start, watch it to completion
  task automatic run_xfer(input bit dir, input logic [AW-1:0] base, input int first,
                          input int count, input int d, input int sbyte, input int sd,
                          input int abyte, input bit restart, input int rbyte,
                          input bit abort_w_start);
    int nb, n_mem, n_map, n_commit, exp_err, exp_exit, n, mw;
    bit exp_done, aborted, fin;
    nb = 2*count;
    n_mem = nb; n_map = dir ? 0 : nb; n_commit = n_map;
    exp_err = 0; exp_done = 1'b1;
    exp_exit = 1;
    for (int j = 0; j < nb; j++) exp_exit += ((j == sbyte) ? sd : d) + 2;
    if (sbyte >= 0 && sd >= TO) begin
      exp_err = 2; exp_done = 1'b0;
      n_mem = sbyte; n_map = dir ? 0 : sbyte; n_commit = n_map;
      exp_exit = 1;
      for (int j = 0; j < sbyte; j++) exp_exit += d + 2;
      exp_exit += dir ? TO + 1 : TO;
    end else if (abyte >= 0) begin
      exp_err = 3; exp_done = 1'b0;
      n_mem = abyte + 1;
      exp_exit = 1;
      for (int j = 0; j <= abyte; j++) exp_exit += ((j == sbyte) ? sd : d) + 2;
    end
    if (rbyte >= 0) begin
      n_mem = rbyte + 1; n_map = rbyte + 1; n_commit = rbyte; exp_done = 1'b0;
    end
    push_expect(dir, base, first, count, n_mem, n_map, n_commit);

    req_base = req_num; ack_d = d; stall_byte = sbyte; stall_d = sd;
    @(posedge Clk); #1;
    Start = 1'b1; Dir = dir; Base = base; First = 5'(first); Count = 6'(count);
    Abort = abort_w_start;
    @(posedge Clk); #1;
    Start = 1'b0; Abort = 1'b0;

    n = 0; mw = 0; aborted = 1'b0; fin = 1'b0;
    while (!fin) begin
      @(negedge Clk);
      n++;
      if (n == 1) check("busy_rise", 32'(Busy), 32'd1);
      check("hold_eq_busy", 32'(Hold), 32'(Busy));
      if (abyte >= 0 && !aborted && (req_num - req_base) == abyte && Mem_Req && !Mem_Ack) begin
        Abort = 1'b1; aborted = 1'b1;
      end else begin
        Abort = 1'b0;
      end
      if (restart) begin
        Start = (n == 3);
        if (n == 3) begin Dir = ~dir; First = 5'd0; Count = 6'd1; end
      end
      if (rbyte >= 0 && MAP_WE && mw == rbyte) begin
        #1 Rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge Clk);
        Rst = 1'b0;
        fin = 1'b1;
      end else begin
        if (MAP_WE) mw++;
        if (!Busy) begin
          fin = 1'b1;
          check("exit_cycle", 32'(n), 32'(exp_exit));
          check("done",       32'(Done), 32'(exp_done));
          check("err",        32'(Err), 32'(exp_err));
          check("req_dropped",32'(Mem_Req), 32'd0);
        end else if (n > 4000) begin
          check("cycle_budget", 32'(n), 32'(exp_exit));
          fin = 1'b1;
        end
      end
    end
    Start = 1'b0; Abort = 1'b0;
    @(negedge Clk);
    check("done_one_cycle", 32'(Done), 32'd0);
    check("idle_after",     32'(Busy), 32'd0);
    check("mem_q_drained",  32'(mem_q.size()), 32'd0);
    check("map_q_drained",  32'(map_q.size()), 32'd0);
    mem_q.delete();
    map_q.delete();
  endtask

  task automatic bad_start(input int first, input int count);
    @(posedge Clk); #1;
    Start = 1'b1; Dir = 1'b0; First = 5'(first); Count = 6'(count);
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("bad_quiet", 32'({Busy, Mem_Req, Sel_MAP, MAP_WE, MAP_RE}), 32'd0);
    end
    check("bad_err", 32'(Err), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] b;
    int f, c;
    repeat (2) @(negedge Clk);
    check_zero("reset");
    Rst = 1'b0;

    // Directed load from the plan
    rd_mem[20'h3F000] = 8'h80; rd_mem[20'h3F001] = 8'h01;
    rd_mem[20'h3F002] = 8'h81; rd_mem[20'h3F003] = 8'h12;
    run_xfer(1'b0, 20'h3F000, 16, 2, 0, -1, 0, -1, 1'b0, -1, 1'b0);
    check("map10", 32'(map_mem[16]), 32'h0180);
    check("map11", 32'(map_mem[17]), 32'h1281);

    // Random loads; one with an ignored mid-transfer Start, one with Start+Abort together
    for (int it = 0; it < 6; it++) begin
      f = $urandom_range(0, 31);
      c = $urandom_range(1, 32 - f);
      b = AW'($urandom);
      fill_image(b, c);
      run_xfer(1'b0, b, f, c, $urandom_range(0, 3), -1, 0, -1, it == 0, -1, it == 1);
      check_map(f, c);
    end

    // Directed save with address wrap
    run_xfer(1'b1, 20'hFFFFE, 30, 2, 0, -1, 0, -1, 1'b0, -1, 1'b0);

    for (int it = 0; it < 4; it++) begin
      f = $urandom_range(0, 31);
      c = $urandom_range(1, 32 - f);
      run_xfer(1'b1, AW'($urandom), f, c, $urandom_range(0, 3), -1, 0, -1, 1'b0, -1, 1'b0);
    end

    // Illegal ranges
    bad_start(5, 0);
    bad_start(31, 2);

    // Ack withheld on the third byte
    b = AW'($urandom);
    fill_image(b, 3);
    run_xfer(1'b0, b, 4, 3, 0, 2, 255, -1, 1'b0, -1, 1'b0);
    check_map(4, 3);

    // Abort during a 3-cycle ack wait, then a clean transfer clears Err
    run_xfer(1'b1, AW'($urandom), 2, 4, 0, 3, 3, 3, 1'b0, -1, 1'b0);
    run_xfer(1'b1, AW'($urandom), 2, 4, 1, -1, 0, -1, 1'b0, -1, 1'b0);

    // Async reset in the third MAP write, then recovery
    b = AW'($urandom);
    fill_image(b, 3);
    run_xfer(1'b0, b, 8, 3, 0, -1, 0, -1, 1'b0, 2, 1'b0);
    check("post_rst_err", 32'(Err), 32'd0);
    check_map(8, 3);
    fill_image(b, 3);
    run_xfer(1'b0, b, 8, 3, 2, -1, 0, -1, 1'b0, -1, 1'b0);
    check_map(8, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
